// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: widths, ALU operation codes,
// the multiply sequencer state type and the operand-forwarding selector.
// Ports: none (package).
package ex_pkg;

  localparam int DATA_W    = 32;
  localparam int REG_AW    = 5;
  localparam int MUL_ITERS = 32;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_SUB  = 4'd3;
  localparam logic [3:0] ALU_SLT  = 4'd4;
  localparam logic [3:0] ALU_SLTU = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_NOR  = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;
  localparam logic [3:0] ALU_MUL  = 4'd12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ex_state_e;

  // MEM beats WB; register 0 is never forwarded.
  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic [DATA_W-1:0] id_val,
    input logic [REG_AW-1:0] idx,
    input logic              mem_we,
    input logic [REG_AW-1:0] mem_rd,
    input logic [DATA_W-1:0] mem_dat,
    input logic              wb_we,
    input logic [REG_AW-1:0] wb_rd,
    input logic [DATA_W-1:0] wb_dat
  );
    logic [DATA_W-1:0] v;
    v = id_val;
    if (mem_we && (mem_rd != '0) && (mem_rd == idx)) begin
      v = mem_dat;
    end else if (wb_we && (wb_rd != '0) && (wb_rd == idx)) begin
      v = wb_dat;
    end
    return v;
  endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one partial-product step per step_i cycle.
// Ports: clk_i/rst_ni, start_i loads operands and clears product/count,
// step_i performs one iteration, abort_i clears everything, done_o flags the
// final iteration cycle, product_o is the low DATA_W bits of the product.
module mul_iter
  import ex_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              step_i,
  input  logic              abort_i,
  input  logic [DATA_W-1:0] mcand_i,
  input  logic [DATA_W-1:0] mplier_i,
  output logic              done_o,
  output logic [DATA_W-1:0] product_o
);

  localparam int CNT_W = $clog2(MUL_ITERS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_ITERS - 1);

  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [DATA_W-1:0] product_q, product_d;
  logic [CNT_W-1:0]  count_q, count_d;

  always_comb begin
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    product_d = product_q;
    count_d   = count_q;
    if (abort_i) begin
      mcand_d   = '0;
      mplier_d  = '0;
      product_d = '0;
      count_d   = '0;
    end else if (start_i) begin
      mcand_d   = mcand_i;
      mplier_d  = mplier_i;
      product_d = '0;
      count_d   = '0;
    end else if (step_i) begin
      if (mplier_q[0]) begin
        product_d = product_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      count_d  = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      product_q <= '0;
      count_q   <= '0;
    end else begin
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      product_q <= product_d;
      count_q   <= count_d;
    end
  end

  assign done_o    = step_i & ~abort_i & (count_q == LAST_CNT);
  assign product_o = product_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch resolution, iterative MUL,
// and the EX/MEM pipeline register.
// Ports: ID/EX instruction fields (I*), forwarding sources (Fwd*), MemStall
// and IFlush in; ExBusy stall, BranchTaken/BranchTarget and EX/MEM (O*) out.
module ex_stage
  import ex_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              IValid,
  input  logic [DATA_W-1:0] IDataA,
  input  logic [DATA_W-1:0] IDataB,
  input  logic [DATA_W-1:0] IImmExt,
  input  logic [DATA_W-1:0] IPC4,
  input  logic [REG_AW-1:0] IRs,
  input  logic [REG_AW-1:0] IRt,
  input  logic [REG_AW-1:0] IRd,
  input  logic              ICRegWrite,
  input  logic              ICMemtoReg,
  input  logic              ICBranch,
  input  logic              ICMemRead,
  input  logic              ICMemWrite,
  input  logic              ICRegDst,
  input  logic              ICALUSrc1,
  input  logic              ICALUSrc2,
  input  logic [3:0]        ICALUCtl,
  input  logic              FwdMemRegWrite,
  input  logic              FwdWbRegWrite,
  input  logic [REG_AW-1:0] FwdMemRd,
  input  logic [REG_AW-1:0] FwdWbRd,
  input  logic [DATA_W-1:0] FwdMemData,
  input  logic [DATA_W-1:0] FwdWbData,
  input  logic              MemStall,
  input  logic              IFlush,
  output logic              ExBusy,
  output logic              BranchTaken,
  output logic [DATA_W-1:0] BranchTarget,
  output logic              OValid,
  output logic              OCRegWrite,
  output logic              OCMemtoReg,
  output logic              OCMemRead,
  output logic              OCMemWrite,
  output logic [DATA_W-1:0] OALUResult,
  output logic [DATA_W-1:0] OStoreData,
  output logic [REG_AW-1:0] ODest
);

  ex_state_e         state_q;
  logic [DATA_W-1:0] fwd_a, fwd_b, src_a, src_b, alu_res, mul_prod;
  logic [4:0]        shamt;
  logic              mul_accept, mul_done, fsm_busy;

  assign fwd_a = fwd_sel(IDataA, IRs, FwdMemRegWrite, FwdMemRd, FwdMemData,
                         FwdWbRegWrite, FwdWbRd, FwdWbData);
  assign fwd_b = fwd_sel(IDataB, IRt, FwdMemRegWrite, FwdMemRd, FwdMemData,
                         FwdWbRegWrite, FwdWbRd, FwdWbData);

  // ALUSrc1 selects the shift-amount field of the immediate.
  assign src_a = ICALUSrc1 ? {{(DATA_W-5){1'b0}}, IImmExt[10:6]} : fwd_a;
  assign src_b = ICALUSrc2 ? IImmExt : fwd_b;
  assign shamt = src_a[4:0];

  always_comb begin
    alu_res = '0;
    case (ICALUCtl)
      ALU_AND:  alu_res = src_a & src_b;
      ALU_OR:   alu_res = src_a | src_b;
      ALU_ADD:  alu_res = src_a + src_b;
      ALU_SUB:  alu_res = src_a - src_b;
      ALU_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      ALU_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (src_a < src_b)};
      ALU_XOR:  alu_res = src_a ^ src_b;
      ALU_NOR:  alu_res = ~(src_a | src_b);
      ALU_SLL:  alu_res = src_b << shamt;
      ALU_SRL:  alu_res = src_b >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(src_b) >>> shamt);
      ALU_LUI:  alu_res = src_b << 16;
      default:  alu_res = '0;  // MUL result comes from mul_iter; 13-15 give 0
    endcase
  end

  assign mul_accept = (state_q == IDLE) & IValid & (ICALUCtl == ALU_MUL) & ~IFlush;
  assign fsm_busy   = mul_accept | (state_q == RUN);

  // Stall and branch are forced low while reset is held, even though the
  // inputs feeding them may be live.
  assign ExBusy       = reset & (MemStall | fsm_busy);
  assign BranchTaken  = reset & IValid & ICBranch & (fwd_a == fwd_b) & ~ExBusy & ~IFlush;
  assign BranchTarget = IPC4 + {IImmExt[DATA_W-3:0], 2'b00};

  mul_iter u_mul (
    .clk_i     (clk),
    .rst_ni    (reset),
    .start_i   (mul_accept),
    .step_i    (state_q == RUN),
    .abort_i   (IFlush & (state_q != IDLE)),
    .mcand_i   (fwd_a),
    .mplier_i  (fwd_b),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );

  // Multiply sequencer. The iterations continue regardless of MemStall;
  // only the hand-off in DONE waits for MEM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: if (mul_accept) state_q <= RUN;
        RUN: begin
          if (IFlush)        state_q <= IDLE;
          else if (mul_done) state_q <= DONE;
        end
        DONE: if (IFlush || !MemStall) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      OValid     <= 1'b0;
      OCRegWrite <= 1'b0;
      OCMemtoReg <= 1'b0;
      OCMemRead  <= 1'b0;
      OCMemWrite <= 1'b0;
      OALUResult <= '0;
      OStoreData <= '0;
      ODest      <= '0;
    end else if (MemStall) begin
      // hold everything
    end else if (IFlush || fsm_busy) begin
      OValid     <= 1'b0;
      OCRegWrite <= 1'b0;
      OCMemtoReg <= 1'b0;
      OCMemRead  <= 1'b0;
      OCMemWrite <= 1'b0;
      OALUResult <= '0;
      OStoreData <= '0;
      ODest      <= '0;
    end else begin
      OValid     <= IValid;
      OCRegWrite <= ICRegWrite & IValid;
      OCMemtoReg <= ICMemtoReg & IValid;
      OCMemRead  <= ICMemRead  & IValid;
      OCMemWrite <= ICMemWrite & IValid;
      // In DONE the held MUL instruction retires with the finished product.
      OALUResult <= (state_q == DONE) ? mul_prod : alu_res;
      OStoreData <= fwd_b;
      ODest      <= ICRegDst ? IRd : IRt;
    end
  end

endmodule
